mem_stage: RTL and testbench

Memory-access stage of the pipeline, directly downstream of the EX-stage ALU. It takes the ALU result as either a pass-through writeback value or an effective address. For loads and stores it runs a req/ack transaction on the data-memory port, generating byte strobes and sign/zero-extending load data. It stalls the upstream pipeline while a transaction is outstanding and presents one registered writeback record per accepted instruction.

---
 rtl/mem_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU passthrough or req/ack data-memory access with byte strobes,
// load extension, upstream stall and a registered one-per-instruction writeback record.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misaligned,
  output logic        fault
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      lo_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;
  logic            mem_read_q;
  logic [31:0]     alu_q;

  logic        is_mem;
  logic        illegal_op;
  logic        misal;
  logic        mem_go;
  logic        timeout;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign is_mem = mem_read | mem_write;

  always_comb begin
    illegal_op = 1'b0;
    if (mem_read && mem_write) begin
      illegal_op = 1'b1;
    end else if (mem_read) begin
      illegal_op = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (mem_write) begin
      illegal_op = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end
  end

  always_comb begin
    misal = 1'b0;
    if (is_mem && !illegal_op) begin
      case (funct3[1:0])
        2'b01:   misal = alu_result[0];
        2'b10:   misal = |alu_result[1:0];
        default: misal = 1'b0;
      endcase
    end
  end

  assign mem_go  = in_valid & is_mem & ~illegal_op & ~misal;
  assign timeout = (state_q == StWait) && (cnt_q == CntLast);

  // Reset masks the stall so a reset cycle never freezes the upstream stage.
  assign stall_out = ~rst & (((state_q == StIdle) & mem_go) |
                             ((state_q == StWait) & ~(dmem_ack | timeout)));

  always_comb begin
    wstrb_d = 4'b1111;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << alu_result[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb_d = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (lo_q)
      2'b00: ld_byte = dmem_rdata[7:0];
      2'b01: ld_byte = dmem_rdata[15:8];
      2'b10: ld_byte = dmem_rdata[23:16];
      2'b11: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lo_q         <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      alu_q        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      misaligned   <= 1'b0;
      fault        <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      fault      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            wb_data <= alu_result;
            wb_rd   <= rd;
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= reg_write;
            end else if (illegal_op) begin
              fault        <= 1'b1;
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
            end else if (misal) begin
              misaligned   <= 1'b1;
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
            end else begin
              dmem_req    <= 1'b1;
              dmem_we     <= mem_write;
              dmem_addr   <= {alu_result[31:2], 2'b00};
              dmem_wstrb  <= mem_write ? wstrb_d : 4'b0000;
              dmem_wdata  <= wdata_d;
              lo_q        <= alu_result[1:0];
              funct3_q    <= funct3;
              rd_q        <= rd;
              reg_write_q <= reg_write;
              mem_read_q  <= mem_read;
              alu_q       <= alu_result;
              cnt_q       <= '0;
              state_q     <= StWait;
            end
          end
        end
        StWait: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_data      <= mem_read_q ? load_data : alu_q;
            wb_rd        <= rd_q;
            wb_reg_write <= reg_write_q & mem_read_q;
            state_q      <= StIdle;
          end else if (timeout) begin
            dmem_req     <= 1'b0;
            fault        <= 1'b1;
            wb_valid     <= 1'b1;
            wb_data      <= alu_q;
            wb_rd        <= rd_q;
            wb_reg_write <= 1'b0;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, loads, stores, misalignment, illegal ops,
// delayed ack, timeout and reset during an outstanding access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        misaligned;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .rd           (rd),
    .reg_write    (reg_write),
    .stall_out    (stall_out),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .misaligned   (misaligned),
    .fault        (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic mr, input logic mw, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] sd, input logic [4:0] r, input logic rw);
    in_valid   = 1'b1;
    mem_read   = mr;
    mem_write  = mw;
    funct3     = f;
    alu_result = a;
    store_data = sd;
    rd         = r;
    reg_write  = rw;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    funct3 = 3'b000; alu_result = '0; store_data = '0; rd = '0; reg_write = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_rw", wb_reg_write, 0);
    check("rst_misal", misaligned, 0);
    check("rst_fault", fault, 0);
    op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd1, 1'b1);
    #1 check("rst_stall", stall_out, 0);
    tick();
    check("rst_hold_req", dmem_req, 0);
    idle();
    rst = 1'b0;
    tick();

    // ALU passthrough, three back-to-back
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
      #1 check("pass_stall", stall_out, 0);
      tick();
      check("pass_wb_valid", wb_valid, 1);
      check("pass_wb_data", wb_data, 32'h0000_1234);
      check("pass_wb_rd", wb_rd, 5);
      check("pass_wb_rw", wb_reg_write, 1);
    end
    idle();
    tick();
    check("pass_end_valid", wb_valid, 0);

    // LB at 0x1003, zero-wait ack
    op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 1'b1);
    #1 check("lb_stall", stall_out, 1);
    tick();
    check("lb_req", dmem_req, 1);
    check("lb_we", dmem_we, 0);
    check("lb_addr", dmem_addr, 32'h0000_1000);
    check("lb_wstrb", dmem_wstrb, 0);
    check("lb_wb_valid_early", wb_valid, 0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80FF_7F01;
    #1 check("lb_ack_stall", stall_out, 0);
    tick();
    check("lb_wb_valid", wb_valid, 1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_wb_rd", wb_rd, 7);
    check("lb_wb_rw", wb_reg_write, 1);
    check("lb_req_drop", dmem_req, 0);

    // LBU at 0x1003 directly after
    dmem_ack = 1'b0;
    op(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd8, 1'b1);
    tick();
    check("lbu_req", dmem_req, 1);
    dmem_ack = 1'b1;
    tick();
    check("lbu_wb_valid", wb_valid, 1);
    check("lbu_wb_data", wb_data, 32'h0000_0080);
    check("lbu_wb_rd", wb_rd, 8);
    dmem_ack = 1'b0;

    // SH at 0x2002
    op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hAAAA_BEEF, 5'd3, 1'b1);
    #1 check("sh_stall", stall_out, 1);
    tick();
    check("sh_req", dmem_req, 1);
    check("sh_we", dmem_we, 1);
    check("sh_addr", dmem_addr, 32'h0000_2000);
    check("sh_wstrb", dmem_wstrb, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    dmem_ack = 1'b1;
    tick();
    check("sh_wb_valid", wb_valid, 1);
    check("sh_wb_rw", wb_reg_write, 0);
    check("sh_wb_data", wb_data, 32'h0000_2002);
    dmem_ack = 1'b0;

    // SB at 0x3001
    op(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h1122_3344, 5'd2, 1'b0);
    tick();
    check("sb_wstrb", dmem_wstrb, 4'b0010);
    check("sb_wdata", dmem_wdata, 32'h4444_4444);
    check("sb_addr", dmem_addr, 32'h0000_3000);
    dmem_ack = 1'b1;
    tick();
    check("sb_wb_valid", wb_valid, 1);
    dmem_ack = 1'b0;

    // LW at 0x0006 misaligned
    op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd6, 1'b1);
    #1 check("misal_stall", stall_out, 0);
    tick();
    check("misal_req", dmem_req, 0);
    check("misal_pulse", misaligned, 1);
    check("misal_wb_valid", wb_valid, 1);
    check("misal_wb_rw", wb_reg_write, 0);
    check("misal_fault", fault, 0);

    // Store with funct3=100 is illegal
    op(1'b0, 1'b1, 3'b100, 32'h0000_0010, 32'h0, 5'd6, 1'b1);
    #1 check("ill_stall", stall_out, 0);
    tick();
    check("ill_fault", fault, 1);
    check("ill_req", dmem_req, 0);
    check("ill_wb_valid", wb_valid, 1);
    check("ill_wb_rw", wb_reg_write, 0);
    check("ill_misal", misaligned, 0);

    // Read and write both set
    op(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 5'd6, 1'b1);
    tick();
    check("rw_fault", fault, 1);
    check("rw_req", dmem_req, 0);
    idle();
    tick();
    check("fault_pulse_end", fault, 0);
    check("wb_pulse_end", wb_valid, 0);

    // LH at 0x5002 with ack delayed 3 cycles
    op(1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0, 5'd4, 1'b1);
    dmem_rdata = 32'h8001_1234;
    #1 check("dly_stall0", stall_out, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("dly_stall", stall_out, 1);
      check("dly_req", dmem_req, 1);
      check("dly_addr", dmem_addr, 32'h0000_5000);
      check("dly_wb_valid", wb_valid, 0);
    end
    tick();
    dmem_ack = 1'b1;
    #1 check("dly_ack_stall", stall_out, 0);
    check("dly_ack_req", dmem_req, 1);
    tick();
    check("dly_wb_valid_done", wb_valid, 1);
    check("dly_wb_data", wb_data, 32'hFFFF_8001);
    check("dly_wb_rd", wb_rd, 4);
    dmem_ack = 1'b0;

    // LW at 0x6000 with no ack: timeout after 4 WAIT cycles
    op(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd10, 1'b1);
    #1 check("to_stall0", stall_out, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("to_wait_stall", stall_out, 1);
      check("to_wait_req", dmem_req, 1);
      check("to_wait_fault", fault, 0);
    end
    tick();
    check("to_last_stall", stall_out, 0);
    check("to_last_req", dmem_req, 1);
    check("to_last_fault", fault, 0);
    tick();
    check("to_fault", fault, 1);
    check("to_req", dmem_req, 0);
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_rw", wb_reg_write, 0);
    idle();
    dmem_ack = 1'b1;
    #1 check("late_ack_stall", stall_out, 0);
    tick();
    check("late_ack_wb", wb_valid, 0);
    check("late_ack_fault", fault, 0);
    check("late_ack_req", dmem_req, 0);
    dmem_ack = 1'b0;

    // Reset in second WAIT cycle, then a normal LW
    op(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd11, 1'b1);
    tick();
    check("rw1_req", dmem_req, 1);
    tick();
    rst = 1'b1;
    #1 check("rw2_stall", stall_out, 0);
    tick();
    check("rstw_req", dmem_req, 0);
    check("rstw_wb_valid", wb_valid, 0);
    rst = 1'b0;
    op(1'b1, 1'b0, 3'b010, 32'h0000_7004, 32'h0, 5'd9, 1'b1);
    #1 check("post_stall", stall_out, 1);
    tick();
    check("post_req", dmem_req, 1);
    check("post_addr", dmem_addr, 32'h0000_7004);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    tick();
    check("post_wb_valid", wb_valid, 1);
    check("post_wb_data", wb_data, 32'h1234_5678);
    check("post_wb_rd", wb_rd, 9);
    check("post_wb_rw", wb_reg_write, 1);
    dmem_ack = 1'b0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
